// File: rtl/stream_switch_demux.sv
// AXI-Stream 1:M packet demultiplexer that isolates the reconfigurable-module port while it is disabled.
// Optional drop statistics are enabled with `define STREAM_SWITCH_DEMUX_STATS_EN.
module stream_switch_demux #(
    parameter int M_COUNT    = 2,
    parameter int CL_M_COUNT = $clog2(M_COUNT),
    parameter int RM_PORT    = M_COUNT - 1,
    parameter int TDATA_W    = 512,
    parameter int TUSER_W    = 48
) (
    input  logic                          axis_aclk,
    input  logic                          axis_areset,
    input  logic [CL_M_COUNT-1:0]         select_committed,
    input  logic                          disable_rm_committed,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [TDATA_W-1:0]            s_axis_tdata,
    input  logic [TDATA_W/8-1:0]          s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic [TUSER_W-1:0]            s_axis_tuser,
    output logic [M_COUNT-1:0]            m_axis_tvalid,
    input  logic [M_COUNT-1:0]            m_axis_tready,
    output logic [M_COUNT*TDATA_W-1:0]    m_axis_tdata,
    output logic [M_COUNT*TDATA_W/8-1:0]  m_axis_tkeep,
    output logic [M_COUNT-1:0]            m_axis_tlast,
    output logic [M_COUNT*TUSER_W-1:0]    m_axis_tuser,
    output logic [31:0]                   drop_count
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    localparam logic [CL_M_COUNT:0]   M_COUNT_EXT = (CL_M_COUNT + 1)'(M_COUNT);
    localparam logic [CL_M_COUNT-1:0] RM_SEL      = CL_M_COUNT'(RM_PORT);

    state_t                  state;
    logic [CL_M_COUNT-1:0]   fwd_port;
    logic [CL_M_COUNT-1:0]   out_port;
    logic                    out_valid;
    logic [TDATA_W-1:0]      out_data;
    logic [TDATA_W/8-1:0]    out_keep;
    logic                    out_last;
    logic [TUSER_W-1:0]      out_user;

    logic                    sel_bad;
    logic                    rm_cut;
    logic                    drop_now;
    logic                    rm_out_disabled;
    logic                    out_flush;
    logic                    out_taken;
    logic                    out_free;
    logic                    accept;
    logic                    load;
    logic [CL_M_COUNT-1:0]   dest;

    // A held RM beat is treated as gone once the RM is disabled, so its tready is never consulted.
    always_comb begin
        sel_bad         = ({1'b0, select_committed} >= M_COUNT_EXT) ||
                          ((select_committed == RM_SEL) && disable_rm_committed);
        rm_cut          = (state == FWD) && (fwd_port == RM_SEL) && disable_rm_committed;
        drop_now        = (state == DROP) || ((state == IDLE) && sel_bad) || rm_cut;
        rm_out_disabled = (out_port == RM_SEL) && disable_rm_committed;
        out_flush       = out_valid && rm_out_disabled;
        out_taken       = out_valid && !rm_out_disabled && m_axis_tready[out_port];
        out_free        = !out_valid || out_taken || out_flush;
        s_axis_tready   = !axis_areset && (drop_now || out_free);
        accept          = s_axis_tvalid && s_axis_tready;
        load            = accept && !drop_now;
        dest            = (state == IDLE) ? select_committed : fwd_port;
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state     <= IDLE;
            fwd_port  <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_port  <= dest;
            end else if (out_free) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_bad) begin
                            state <= s_axis_tlast ? IDLE : DROP;
                        end else begin
                            fwd_port <= select_committed;
                            state    <= s_axis_tlast ? IDLE : FWD;
                        end
                    end
                end
                FWD: begin
                    // RM disabled mid-packet: discard the rest, leaving a truncated packet at the RM.
                    if (rm_cut) begin
                        state <= (accept && s_axis_tlast) ? IDLE : DROP;
                    end else if (accept && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (accept && s_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (load) begin
            out_data <= s_axis_tdata;
            out_keep <= s_axis_tkeep;
            out_last <= s_axis_tlast;
            out_user <= s_axis_tuser;
        end
    end

    for (genvar i = 0; i < M_COUNT; i++) begin : g_valid
        assign m_axis_tvalid[i] = out_valid && (out_port == CL_M_COUNT'(i)) &&
                                  !((i == RM_PORT) && disable_rm_committed);
    end

    assign m_axis_tdata = {M_COUNT{out_data}};
    assign m_axis_tkeep = {M_COUNT{out_keep}};
    assign m_axis_tlast = {M_COUNT{out_last}};
    assign m_axis_tuser = {M_COUNT{out_user}};

`ifdef STREAM_SWITCH_DEMUX_STATS_EN
    logic [31:0] drop_cnt;

    // Counts whole packets rejected on their first beat; truncated RM packets are not counted.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            drop_cnt <= 32'd0;
        end else if ((state == IDLE) && accept && sel_bad && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 32'd0;
`endif

endmodule
